// File: rtl/bo_pkg.sv
// bo_pkg: encodings shared by the bo_datapath operative block and its FSM
// control block.
//   SEL_*  : ALU operand select codes (M0 for A, M1 for B)
//   WB_*   : write-back bus select codes (M2)
//   OP_*   : ALU operation code (H)
package bo_pkg;

    // ALU A select (M0) and B select (M1). The code 2'b11 means
    // K_CONST on the A side and B_IN on the B side.
    localparam logic [1:0] SEL_X   = 2'b00;
    localparam logic [1:0] SEL_HR  = 2'b01;
    localparam logic [1:0] SEL_S   = 2'b10;
    localparam logic [1:0] SEL_K   = 2'b11;
    localparam logic [1:0] SEL_BIN = 2'b11;

    // Write-back bus select (M2)
    localparam logic [1:0] WB_ALU  = 2'b00;
    localparam logic [1:0] WB_XIN  = 2'b01;
    localparam logic [1:0] WB_ZERO = 2'b10;
    localparam logic [1:0] WB_K    = 2'b11;

    // ALU operation (H)
    localparam logic OP_ADD = 1'b0;
    localparam logic OP_MUL = 1'b1;

endpackage

// File: rtl/bo_alu.sv
// bo_alu: combinational two-operation ALU (unsigned add / unsigned multiply).
//   a, b : WIDTH-bit unsigned operands
//   h    : OP_ADD or OP_MUL
//   r    : result truncated modulo 2^WIDTH
//   ovf  : 1 when the truncated high part of the full-precision result is nonzero
module bo_alu #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             h,
    output logic [WIDTH-1:0] r,
    output logic             ovf
);
    import bo_pkg::*;

    logic [WIDTH:0]     sum_p0;
    logic [2*WIDTH-1:0] prod_p0;

    // Wrap-around only: keep the low WIDTH bits of the product.
    function automatic logic [WIDTH-1:0] wrap_prod(input logic [2*WIDTH-1:0] p);
        return p[WIDTH-1:0];
    endfunction

    function automatic logic [WIDTH-1:0] wrap_sum(input logic [WIDTH:0] s);
        return s[WIDTH-1:0];
    endfunction

    assign sum_p0  = {1'b0, a} + {1'b0, b};
    assign prod_p0 = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};

    always_comb begin
        r   = wrap_sum(sum_p0);
        ovf = sum_p0[WIDTH];
        if (h == OP_MUL) begin
            r   = wrap_prod(prod_p0);
            ovf = |prod_p0[2*WIDTH-1:WIDTH];
        end
    end

endmodule

// File: rtl/bo_datapath.sv
// bo_datapath: operative block executing one micro-operation per rising edge
// from the control word (H, LX, LH, LS, M0, M1, M2).
//   clk, rst        : clock, asynchronous active-low reset
//   X_IN, B_IN      : external operand (write-back source) and ALU B operand
//   H               : ALU op (add / multiply)
//   LX, LH, LS      : load enables for X, HR, S (all take the same WB value)
//   M0, M1, M2      : ALU A select, ALU B select, write-back select
//   S_OUT, X_OUT, H_OUT : register contents
//   OVF             : sticky overflow, ZERO : S == 0 (combinational)
module bo_datapath #(
    parameter int WIDTH   = 8,
    parameter int K_CONST = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] X_IN,
    input  logic [WIDTH-1:0] B_IN,
    input  logic             H,
    input  logic             LX,
    input  logic             LH,
    input  logic             LS,
    input  logic [1:0]       M0,
    input  logic [1:0]       M1,
    input  logic [1:0]       M2,
    output logic [WIDTH-1:0] S_OUT,
    output logic [WIDTH-1:0] X_OUT,
    output logic [WIDTH-1:0] H_OUT,
    output logic             OVF,
    output logic             ZERO
);
    import bo_pkg::*;

    localparam logic [WIDTH-1:0] K_VAL = WIDTH'(K_CONST);

    logic [WIDTH-1:0] x_p1, hr_p1, s_p1;
    logic             ovf_p1;

    logic [WIDTH-1:0] a_p0, b_p0, r_p0, wb_p0;
    logic             alu_ovf_p0;
    logic             any_load_p0;

    // Stage p0: operand select, ALU and write-back bus from pre-edge registers
    always_comb begin
        case (M0)
            SEL_X:   a_p0 = x_p1;
            SEL_HR:  a_p0 = hr_p1;
            SEL_S:   a_p0 = s_p1;
            default: a_p0 = K_VAL;
        endcase
    end

    always_comb begin
        case (M1)
            SEL_X:   b_p0 = x_p1;
            SEL_HR:  b_p0 = hr_p1;
            SEL_S:   b_p0 = s_p1;
            default: b_p0 = B_IN;
        endcase
    end

    bo_alu #(.WIDTH(WIDTH)) u_alu (
        .a   (a_p0),
        .b   (b_p0),
        .h   (H),
        .r   (r_p0),
        .ovf (alu_ovf_p0)
    );

    always_comb begin
        case (M2)
            WB_ALU:  wb_p0 = r_p0;
            WB_XIN:  wb_p0 = X_IN;
            WB_ZERO: wb_p0 = '0;
            default: wb_p0 = K_VAL;
        endcase
    end

    assign any_load_p0 = LX | LH | LS;

    // Stage p1: register write-back and sticky overflow
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            x_p1   <= '0;
            hr_p1  <= '0;
            s_p1   <= '0;
            ovf_p1 <= 1'b0;
        end else begin
            if (LX) x_p1  <= wb_p0;
            if (LH) hr_p1 <= wb_p0;
            if (LS) s_p1  <= wb_p0;
            // Zeroing S starts a new computation, so the clear outranks a set.
            if (M2 == WB_ZERO && LS)
                ovf_p1 <= 1'b0;
            else if (M2 == WB_ALU && any_load_p0 && alu_ovf_p0)
                ovf_p1 <= 1'b1;
        end
    end

    assign S_OUT = s_p1;
    assign X_OUT = x_p1;
    assign H_OUT = hr_p1;
    assign OVF   = ovf_p1;
    assign ZERO  = (s_p1 == '0);

endmodule

// File: tb/tb_bo_datapath.sv
module tb_bo_datapath;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] X_IN, B_IN;
    logic       H, LX, LH, LS;
    logic [1:0] M0, M1, M2;
    logic [7:0] S_OUT, X_OUT, H_OUT;
    logic       OVF, ZERO;

    bo_datapath #(.WIDTH(8), .K_CONST(1)) dut (
        .clk(clk), .rst(rst), .X_IN(X_IN), .B_IN(B_IN), .H(H),
        .LX(LX), .LH(LH), .LS(LS), .M0(M0), .M1(M1), .M2(M2),
        .S_OUT(S_OUT), .X_OUT(X_OUT), .H_OUT(H_OUT), .OVF(OVF), .ZERO(ZERO)
    );

    always #5 clk = ~clk;

    typedef struct {
        int    x, hr, s, ovf;
        string tag;
    } exp_t;

    exp_t q[$];

    // Reference state as plain integers
    int mx, mhr, ms, movf;
    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_all(input string tag, input int x, input int hr, input int s, input int ovf);
        chk({tag, ".X"},    int'(X_OUT), x);
        chk({tag, ".HR"},   int'(H_OUT), hr);
        chk({tag, ".S"},    int'(S_OUT), s);
        chk({tag, ".OVF"},  int'(OVF),   ovf);
        chk({tag, ".ZERO"}, int'(ZERO),  (s == 0) ? 1 : 0);
    endtask

    function automatic int pick(input int sel, input int bside, input int bin);
        case (sel)
            0: return mx;
            1: return mhr;
            2: return ms;
            default: return bside ? bin : 1;
        endcase
    endfunction

    // Present one control word before the next rising edge and predict the result.
    task automatic apply(input string tag, input int h, input int lx, input int lh, input int ls,
                         input int m0, input int m1, input int m2, input int xin, input int bin);
        int a, b, r, wb;
        exp_t e;
        @(negedge clk);
        H = h[0]; LX = lx[0]; LH = lh[0]; LS = ls[0];
        M0 = m0[1:0]; M1 = m1[1:0]; M2 = m2[1:0];
        X_IN = xin[7:0]; B_IN = bin[7:0];
        a = pick(m0, 0, bin);
        b = pick(m1, 1, bin);
        r = h ? a * b : a + b;
        case (m2)
            0: wb = r % 256;
            1: wb = xin;
            2: wb = 0;
            default: wb = 1;
        endcase
        if (m2 == 2 && ls != 0)
            movf = 0;
        else if (m2 == 0 && (lx | lh | ls) != 0 && r > 255)
            movf = 1;
        if (lx != 0) mx = wb;
        if (lh != 0) mhr = wb;
        if (ls != 0) ms = wb;
        e.x = mx; e.hr = mhr; e.s = ms; e.ovf = movf; e.tag = tag;
        q.push_back(e);
    endtask

    // Monitor: every edge that has a predicted result is checked just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk_all(e.tag, e.x, e.hr, e.s, e.ovf);
            end
        end
    end

    initial begin
        rst = 1'b0;
        X_IN = '0; B_IN = '0; H = 0; LX = 0; LH = 0; LS = 0; M0 = 0; M1 = 0; M2 = 0;
        mx = 0; mhr = 0; ms = 0; movf = 0;
        repeat (2) @(negedge clk);
        chk_all("por", 0, 0, 0, 0);
        rst = 1'b1;

        // Polynomial x^2 + x with x = 3
        apply("poly1", 0, 1, 0, 0, 0, 0, 1, 3, 0);
        apply("poly2", 1, 0, 1, 0, 0, 0, 0, 0, 0);
        apply("poly3", 0, 0, 0, 1, 1, 0, 0, 0, 0);

        // Overflow on add, sticky across a clean add, cleared by zeroing S
        apply("ovf_ldx", 0, 1, 0, 0, 0, 0, 1, 200, 0);
        apply("ovf_add", 0, 0, 0, 1, 0, 0, 0, 0, 0);
        apply("ovf_sticky", 0, 0, 0, 1, 3, 3, 0, 0, 1);
        apply("ovf_clr", 0, 0, 0, 1, 0, 0, 2, 0, 0);

        // All three registers loaded together
        apply("simul", 0, 1, 1, 1, 0, 0, 1, 8'h2A, 0);

        // S <= S + X repeatedly, then hold
        apply("self_lds", 0, 0, 0, 1, 0, 0, 1, 10, 0);
        apply("self_ldx", 0, 1, 0, 0, 0, 0, 1, 4, 0);
        for (int i = 0; i < 3; i++) apply("self_acc", 0, 0, 0, 1, 2, 0, 0, 0, 0);
        for (int i = 0; i < 2; i++) apply("self_hold", 1, 0, 0, 0, 2, 3, 0, 0, 255);

        // Multiply overflow: ignored without a load, sets OVF with LH
        apply("mul_ldx", 0, 1, 0, 0, 0, 0, 1, 16, 0);
        apply("mul_noload", 1, 0, 0, 0, 0, 0, 0, 0, 0);
        apply("mul_ldh", 1, 0, 1, 0, 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run with X = 5, S = 7
        apply("rst_ldx", 0, 1, 0, 0, 0, 0, 1, 5, 0);
        apply("rst_lds", 0, 0, 0, 1, 0, 0, 1, 7, 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_all("async_rst", 0, 0, 0, 0);
        mx = 0; mhr = 0; ms = 0; movf = 0;
        H = 0; LX = 0; LH = 0; LS = 0; M0 = 0; M1 = 0; M2 = 0;
        @(negedge clk);
        chk_all("rst_hold", 0, 0, 0, 0);
        rst = 1'b1;

        // Random micro-operations
        for (int i = 0; i < 400; i++) begin
            int en, m2r;
            en  = $urandom_range(0, 7);
            m2r = $urandom_range(0, 9);
            apply("rand", $urandom_range(0, 1), en & 1, (en >> 1) & 1, (en >> 2) & 1,
                  $urandom_range(0, 3), $urandom_range(0, 3),
                  (m2r < 6) ? 0 : m2r - 6, $urandom_range(0, 255), $urandom_range(0, 255));
        end
        apply("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #2;
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL drain: %0d results outstanding, expected 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/bo_datapath.md
Name: bo_datapath

Overview:
- Operative block (datapath) that consumes the control word from the existing FSM control block: H, LX, LH, LS, M0, M1, M2.
- Holds three working registers, X, HR and S, plus an operand-select network, a two-operation ALU and a sticky overflow flag.
- Purely a responder: it executes whatever micro-operation the control block presents on each rising edge.
- Top level instantiates it beside the FSM; S_OUT is the computed result.

Parameters:
- WIDTH, 8, data width of the registers, the ALU and the inputs.
- K_CONST, 1, constant selectable as an ALU operand and as a write-back source.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- X_IN  in  WIDTH  external operand, loadable into any register.
- B_IN  in  WIDTH  external ALU B operand.
- H  in  1  ALU operation: 0 = add, 1 = multiply.
- LX  in  1  load enable, register X.
- LH  in  1  load enable, register HR.
- LS  in  1  load enable, register S.
- M0  in  2  ALU A select: 00 X, 01 HR, 10 S, 11 K_CONST.
- M1  in  2  ALU B select: 00 X, 01 HR, 10 S, 11 B_IN.
- M2  in  2  write-back select: 00 ALU result, 01 X_IN, 10 zero, 11 K_CONST.
- S_OUT  out  WIDTH  register S.
- X_OUT  out  WIDTH  register X (debug/observe).
- H_OUT  out  WIDTH  register HR (debug/observe).
- OVF  out  1  sticky overflow flag.
- ZERO  out  1  combinational, S == 0.

Behaviour:
- Reset:
  - rst low asynchronously clears X, HR, S and OVF to 0.
  - So ZERO = 1 during and after reset.
  - Reset mid-computation discards all state immediately; there is no pending-operation memory.
- Registered state: X, HR, S, OVF. Everything else is combinational:
  - ALU operands A and B;
  - full-precision result R (WIDTH+1 bits for add, 2*WIDTH bits for multiply);
  - write-back bus WB.
- Operand path:
  - A = mux(M0), B = mux(M1), always from pre-edge register values.
  - So reading and writing the same register in one cycle is legal (e.g. S <= S + X).
- ALU:
  - add: R = A + B; WB = R[WIDTH-1:0] when M2 = 00.
  - multiply: R = A * B, unsigned; WB = R[WIDTH-1:0] when M2 = 00.
- Write-back:
  - One shared bus WB = mux(M2).
  - On each rising edge, every register whose load enable is 1 takes WB.
  - LX, LH and LS may be asserted together; all selected registers receive the identical value.
  - Registers with their enable at 0 hold.
- Latency:
  - A result is visible on the register outputs one cycle after the control word is presented.
  - Chained micro-operations need one control word per cycle; there are no stalls or bubbles.
- OVF:
  - Set on an edge where M2 = 00, any load enable is 1, and the truncated bits of R are nonzero.
  - Cleared on an edge where M2 = 10 and LS = 1 (zeroing S starts a new computation).
  - If both set and clear conditions hold on one edge, the clear wins.
  - Otherwise OVF holds.
  - An ALU overflow with no load enable active does not set OVF.
- Control word with all load enables 0: no state change, regardless of M0, M1, M2 and H.
- Unknown/X on the control inputs is outside the contract; the bench drives known values after reset.
- Wrap-around: modulo 2^WIDTH truncation only; no saturation.

Decomposition:
- Shared package bo_pkg holds:
  - the select encodings: SEL_X, SEL_HR, SEL_S, SEL_K, SEL_BIN, WB_ALU, WB_XIN, WB_ZERO, WB_K;
  - the ALU op encodings OP_ADD and OP_MUL.
- The same package is used by the FSM.
- One natural sub-module: bo_alu, combinational. It takes A, B and H and produces the WIDTH-bit result plus an overflow bit.
- Registers and muxes live in bo_datapath.

Test Plan:
1. Reset: drive rst low mid-run with X = 5 and S = 7 -> X, HR, S = 0, OVF = 0, ZERO = 1 immediately, without waiting for an edge.
2. Polynomial x^2 + x, WIDTH = 8, X_IN = 3, three cycles:
   - cycle 1: M2 = 01, LX -> X = 3;
   - cycle 2: M0 = 00, M1 = 00, H = 1, M2 = 00, LH -> HR = 9;
   - cycle 3: M0 = 01, M1 = 00, H = 0, M2 = 00, LS -> S = 12; OVF = 0.
3. Overflow and clear:
   - load X = 200 then S <= X + X -> S = 144, OVF = 1;
   - next add 1 + 1 into S -> OVF stays 1;
   - M2 = 10 with LS -> S = 0, OVF = 0.
4. Simultaneous loads: X_IN = 0x2A, M2 = 01, LX = LH = LS = 1 -> X = HR = S = 0x2A after one edge.
5. Self-update: S = 10, X = 4, M0 = 10, M1 = 00, H = 0, M2 = 00, LS for 3 cycles -> S = 14, 18, 22; no enables for 2 cycles -> S holds 22.
6. Multiply overflow with no load: X = 16, X*X, all enables 0 -> OVF stays 0 and no register changes. The same word with LH -> HR = 0, OVF = 1.
